sipo_frame_rx: RTL and testbench
================================

# sipo_frame_rx

Serial-to-parallel frame receiver that sits directly downstream of the serial shift stage. It samples the single-bit `data_out` stream of that stage once per clock and delineates frames (start bit, DATA_W data bits LSB first, optional parity, stop bit). It presents each good frame as a parallel word with a one-cycle valid pulse, and flags framing and parity faults.

## Interface
- `DATA_W`, default 8: data bits per frame. Legal range is 2 to 32.
- `clk`, input, 1: the single clock. All sampling and state updates happen on the rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `data_in`, input, 1: serial line, driven by the upstream shift stage's `data_out`.
- `data_out`, output, DATA_W: last correctly received word.
- `valid`, output, 1: one-cycle pulse; `data_out` has just been updated.
- `frame_err`, output, 1: one-cycle pulse; the stop bit was wrong.
- `parity_err`, output, 1: one-cycle pulse; parity mismatch. Present only with PARITY_CHECK_EN; otherwise it is not a port.
- `busy`, output, 1: high while a frame is in progress, i.e. state is not IDLE.

## Operation
- Line idles at 0. Frame format: start = 1, then DATA_W data bits LSB first, then the parity bit (only when enabled), then stop = 0.
- FSM states are IDLE, DATA, PARITY, STOP. All state is registered. Exactly one bit is consumed per `clk` edge.
- IDLE: if `data_in`=1, go to DATA and clear the bit counter. Otherwise stay in IDLE.
- DATA: shift `data_in` into shift register bit [cnt]; cnt++. After the DATA_W-th bit, go to PARITY if enabled, else STOP.
- Bit counter is $clog2(DATA_W) wide. It never wraps inside a frame; terminal count is DATA_W-1.
- PARITY: compare `data_in` with the even parity (XOR) of the shifted word. Latch a mismatch flag. Go to STOP.
- STOP, with `data_in`=0 and no parity mismatch: copy the shift register to `data_out`, pulse `valid`.
- STOP, with `data_in`=1: pulse `frame_err`. `data_out` is unchanged and there is no `valid`. This 1 is NOT taken as a new start bit.
- STOP, with a parity mismatch: pulse `parity_err`, no `valid`. If the stop bit is also bad, pulse `frame_err` in the same cycle.
- STOP always goes to IDLE.
- `data_out` holds its value indefinitely between good frames.
- `rst` mid-frame: abandon the frame, go to IDLE, raise no error pulse.
- `rst` takes priority over every other event on the same edge.

## Timing
- Reset values: state=IDLE, `data_out`=0, `valid`=0, `frame_err`=0, `parity_err`=0, `busy`=0, counter=0, shift register=0.
- Label the edge that samples the start bit as E0.
- Data bits are sampled at E1..E_DATA_W.
- Without parity:
  - Stop bit is sampled at E(DATA_W+1).
  - `valid`/`frame_err` are high for exactly the cycle following that edge.
- With parity:
  - Parity is sampled at E(DATA_W+1) and stop at E(DATA_W+2).
  - Pulses fall one edge later than without parity.
- `busy` rises after E0 and falls after the stop edge.
- Back-to-back frames: a start bit presented on the edge immediately after the stop edge is accepted, so no idle gap is required.
- Sustained throughput is one word per DATA_W+2 clocks without parity, DATA_W+3 with parity.
- `valid`, `frame_err` and `parity_err` are never high for more than one consecutive cycle.

## Configuration
- Macro: `SIPO_FRAME_RX_PARITY_CHECK_EN`.
- Defined:
  - The PARITY state exists and the frame is DATA_W+3 bits.
  - The `parity_err` port exists.
  - Even parity is checked.
- Undefined:
  - There is no PARITY state, no mismatch flag and no `parity_err` port.
  - The frame is DATA_W+2 bits.
  - DATA goes straight to STOP.

## Test plan
- Reset, then an idle line (0) for 20 cycles: all outputs stay 0 and `busy`=0 throughout.
- DATA_W=8, no parity. Send 1,1,0,1,0,0,1,0,1,0 (0xA5 framed): `valid` is high for one cycle after E9, `data_out`=0xA5, `frame_err`=0.
- Same frame but stop bit = 1: `frame_err` pulses after E9, `valid`=0, `data_out` keeps its previous value. The FSM returns to IDLE and the following 0s produce no start.
- Back-to-back 0x3C then 0xC3 with no gap: two `valid` pulses 10 cycles apart, `data_out` equal to 0x3C then 0xC3.
- PARITY_CHECK_EN, send 0xA5 with parity bit 0: `valid` after E10. Resend 0xA5 with parity bit 1: `parity_err` pulses after E10, no `valid`.
- Assert `rst` for one cycle at E5 of a frame: `busy` drops, no pulses. A new 0x5A frame sent afterwards is received correctly.

Source files
------------

// File: rtl/sipo_frame_rx.sv
// Serial frame receiver: start bit (1), DATA_W data bits LSB first, optional even parity, stop bit (0).
// Optional parity checking is enabled by defining SIPO_FRAME_RX_PARITY_CHECK_EN.
module sipo_frame_rx #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              valid,
  output logic              frame_err,
`ifdef SIPO_FRAME_RX_PARITY_CHECK_EN
  output logic              parity_err,
`endif
  output logic              busy
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

`ifdef SIPO_FRAME_RX_PARITY_CHECK_EN
  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [1:0] {IDLE, DATA, STOP} state_t;
`endif

  state_t            state;
  logic [DATA_W-1:0] shift_reg;
  logic [CNT_W-1:0]  cnt;
  logic              par_mismatch;

`ifdef SIPO_FRAME_RX_PARITY_CHECK_EN
  logic par_bad;
  assign par_mismatch = par_bad;
`else
  assign par_mismatch = 1'b0;
`endif

  // A stop bit of 1 is never reused as a start bit: STOP always returns to IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      shift_reg <= '0;
      cnt       <= '0;
      data_out  <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
      busy      <= 1'b0;
`ifdef SIPO_FRAME_RX_PARITY_CHECK_EN
      par_bad    <= 1'b0;
      parity_err <= 1'b0;
`endif
    end else begin
      valid     <= 1'b0;
      frame_err <= 1'b0;
`ifdef SIPO_FRAME_RX_PARITY_CHECK_EN
      parity_err <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (data_in) begin
            state <= DATA;
            cnt   <= '0;
            busy  <= 1'b1;
          end
        end
        DATA: begin
          shift_reg[cnt] <= data_in;
          if (cnt == LAST_BIT) begin
`ifdef SIPO_FRAME_RX_PARITY_CHECK_EN
            state <= PARITY;
`else
            state <= STOP;
`endif
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
`ifdef SIPO_FRAME_RX_PARITY_CHECK_EN
        PARITY: begin
          par_bad <= (data_in != (^shift_reg));
          state   <= STOP;
        end
`endif
        STOP: begin
          state <= IDLE;
          busy  <= 1'b0;
          if (data_in)
            frame_err <= 1'b1;
`ifdef SIPO_FRAME_RX_PARITY_CHECK_EN
          if (par_bad)
            parity_err <= 1'b1;
          par_bad <= 1'b0;
`endif
          if (!data_in && !par_mismatch) begin
            data_out <= shift_reg;
            valid    <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sipo_frame_rx.sv
// Self-checking bench for sipo_frame_rx; builds a per-edge expectation stream from whole frames.
// Define SIPO_FRAME_RX_PARITY_CHECK_EN to exercise the parity variant.
module tb_sipo_frame_rx;

  localparam int DW = 8;
  localparam int EW = DW + 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          data_in = 1'b0;
  logic [DW-1:0] data_out;
  logic          valid;
  logic          frame_err;
  logic          busy;
  logic          parity_err_w;

  int checks = 0;
  int errors = 0;

  logic          bits_q[$];
  logic          rst_q[$];
  logic [EW-1:0] exp_q[$];
  logic [DW-1:0] cur_data = '0;

  sipo_frame_rx #(.DATA_W(DW)) dut (
    .clk(clk),
    .rst(rst),
    .data_in(data_in),
    .data_out(data_out),
    .valid(valid),
    .frame_err(frame_err),
`ifdef SIPO_FRAME_RX_PARITY_CHECK_EN
    .parity_err(parity_err_w),
`endif
    .busy(busy)
  );

`ifndef SIPO_FRAME_RX_PARITY_CHECK_EN
  assign parity_err_w = 1'b0;
`endif

  always #5 clk = ~clk;

  // Expected outputs after each edge, packed as {valid, frame_err, parity_err, busy, data_out}.
  task automatic add_idle(input int n);
    for (int i = 0; i < n; i++) begin
      bits_q.push_back(1'b0);
      rst_q.push_back(1'b0);
      exp_q.push_back({4'b0000, cur_data});
    end
  endtask

  task automatic add_frame(input logic [DW-1:0] word, input logic stop_bit, input logic par_flip);
    int len;
    logic pf;
    logic good;
`ifdef SIPO_FRAME_RX_PARITY_CHECK_EN
    pf  = par_flip;
    len = DW + 3;
`else
    pf  = 1'b0;
    len = DW + 2;
`endif
    bits_q.push_back(1'b1);
    for (int i = 0; i < DW; i++) bits_q.push_back(word[i]);
`ifdef SIPO_FRAME_RX_PARITY_CHECK_EN
    bits_q.push_back((^word) ^ pf);
`endif
    bits_q.push_back(stop_bit);
    for (int i = 0; i < len; i++) rst_q.push_back(1'b0);
    for (int i = 0; i < len - 1; i++) exp_q.push_back({4'b0001, cur_data});
    good = !stop_bit && !pf;
    if (good) cur_data = word;
    exp_q.push_back({good, stop_bit, pf, 1'b0, cur_data});
  endtask

  task automatic clear_model();
    bits_q.delete();
    rst_q.delete();
    exp_q.delete();
  endtask

  task automatic drive_bit(input logic b, input logic r);
    data_in = b;
    rst     = r;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst     = 1'b1;
    data_in = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({valid, frame_err, parity_err_w, busy, data_out} !== {EW{1'b0}}) begin
      errors++;
      $display("[TB] FAIL reset_state got %h exp %h", {valid, frame_err, parity_err_w, busy, data_out}, {EW{1'b0}});
    end
    cur_data = '0;
    clear_model();
    add_idle(20);
    for (int k = 0; k < bits_q.size(); k++) begin
      drive_bit(bits_q[k], rst_q[k]);
      checks++;
      if ({valid, frame_err, parity_err_w, busy, data_out} !== exp_q[k]) begin
        errors++;
        $display("[TB] FAIL idle_line edge %0d got %h exp %h", k, {valid, frame_err, parity_err_w, busy, data_out}, exp_q[k]);
      end
    end
  endtask

  task automatic test_good_frame();
    clear_model();
    add_frame(8'hA5, 1'b0, 1'b0);
    add_idle(3);
    for (int k = 0; k < bits_q.size(); k++) begin
      drive_bit(bits_q[k], rst_q[k]);
      checks++;
      if ({valid, frame_err, parity_err_w, busy, data_out} !== exp_q[k]) begin
        errors++;
        $display("[TB] FAIL good_frame edge %0d got %h exp %h", k, {valid, frame_err, parity_err_w, busy, data_out}, exp_q[k]);
      end
    end
  endtask

  task automatic test_frame_error();
    clear_model();
    add_frame(8'h5C, 1'b0, 1'b0);
    add_frame(8'hA5, 1'b1, 1'b0);
    add_idle(6);
    for (int k = 0; k < bits_q.size(); k++) begin
      drive_bit(bits_q[k], rst_q[k]);
      checks++;
      if ({valid, frame_err, parity_err_w, busy, data_out} !== exp_q[k]) begin
        errors++;
        $display("[TB] FAIL frame_error edge %0d got %h exp %h", k, {valid, frame_err, parity_err_w, busy, data_out}, exp_q[k]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int valid_edges[$];
    clear_model();
    add_frame(8'h3C, 1'b0, 1'b0);
    add_frame(8'hC3, 1'b0, 1'b0);
    add_idle(2);
    for (int k = 0; k < bits_q.size(); k++) begin
      drive_bit(bits_q[k], rst_q[k]);
      if (valid === 1'b1) valid_edges.push_back(k);
      checks++;
      if ({valid, frame_err, parity_err_w, busy, data_out} !== exp_q[k]) begin
        errors++;
        $display("[TB] FAIL back_to_back edge %0d got %h exp %h", k, {valid, frame_err, parity_err_w, busy, data_out}, exp_q[k]);
      end
    end
    checks++;
`ifdef SIPO_FRAME_RX_PARITY_CHECK_EN
    if (valid_edges.size() != 2 || valid_edges[1] - valid_edges[0] != DW + 3) begin
`else
    if (valid_edges.size() != 2 || valid_edges[1] - valid_edges[0] != DW + 2) begin
`endif
      errors++;
      $display("[TB] FAIL back_to_back_spacing got %0d pulses exp 2 at frame spacing", valid_edges.size());
    end
  endtask

`ifdef SIPO_FRAME_RX_PARITY_CHECK_EN
  task automatic test_parity();
    clear_model();
    add_frame(8'hA5, 1'b0, 1'b0);
    add_frame(8'hA5, 1'b0, 1'b1);
    add_frame(8'h81, 1'b1, 1'b1);
    add_idle(3);
    for (int k = 0; k < bits_q.size(); k++) begin
      drive_bit(bits_q[k], rst_q[k]);
      checks++;
      if ({valid, frame_err, parity_err_w, busy, data_out} !== exp_q[k]) begin
        errors++;
        $display("[TB] FAIL parity edge %0d got %h exp %h", k, {valid, frame_err, parity_err_w, busy, data_out}, exp_q[k]);
      end
    end
  endtask
`endif

  task automatic test_reset_midframe();
    logic [DW-1:0] partial;
    clear_model();
    partial = 8'hF0;
    bits_q.push_back(1'b1);
    for (int i = 0; i < 4; i++) bits_q.push_back(partial[i]);
    for (int i = 0; i < 5; i++) begin
      rst_q.push_back(1'b0);
      exp_q.push_back({4'b0001, cur_data});
    end
    bits_q.push_back(1'b1);
    rst_q.push_back(1'b1);
    cur_data = '0;
    exp_q.push_back({EW{1'b0}});
    add_idle(2);
    add_frame(8'h5A, 1'b0, 1'b0);
    add_idle(2);
    for (int k = 0; k < bits_q.size(); k++) begin
      drive_bit(bits_q[k], rst_q[k]);
      checks++;
      if ({valid, frame_err, parity_err_w, busy, data_out} !== exp_q[k]) begin
        errors++;
        $display("[TB] FAIL reset_midframe edge %0d got %h exp %h", k, {valid, frame_err, parity_err_w, busy, data_out}, exp_q[k]);
      end
    end
  endtask

  task automatic test_random();
    clear_model();
    for (int f = 0; f < 40; f++) begin
      add_frame(DW'($urandom), ($urandom_range(0, 4) == 0), ($urandom_range(0, 4) == 0));
      add_idle($urandom_range(0, 2));
    end
    add_idle(2);
    for (int k = 0; k < bits_q.size(); k++) begin
      drive_bit(bits_q[k], rst_q[k]);
      checks++;
      if ({valid, frame_err, parity_err_w, busy, data_out} !== exp_q[k]) begin
        errors++;
        $display("[TB] FAIL random edge %0d got %h exp %h", k, {valid, frame_err, parity_err_w, busy, data_out}, exp_q[k]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_frame_error();
    test_back_to_back();
`ifdef SIPO_FRAME_RX_PARITY_CHECK_EN
    test_parity();
`endif
    test_reset_midframe();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
